// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single RV32IM register-file write port between the in-order
// pipeline writeback stage (WB) and the multi-cycle mul/div unit (MD).
//
// WB is never back-pressured and always wins the port when it targets a
// non-zero register. MD results wait in a small FIFO. The FIFO head is
// written in any cycle WB leaves the port free.
//
// Supporting features:
//   - Write-after-write kill: a WB write to rd=r marks every queued entry
//     with rd=r dead, so the older MD value can never overwrite the newer
//     WB value.
//   - Dead heads: killed entries and rd=0 entries are popped without
//     using the port.
//   - Starvation guard: a saturating counter of cycles in which a live
//     head lost to WB. Once it reaches STARVE_LIMIT, stall_req asks the
//     pipeline to insert a writeback bubble.
//   - Pending-destination mask: the hazard unit uses it to interlock on
//     registers that still have an MD result in flight.
//
// Parameters:
//   DEPTH        : FIFO entries (power of two, >= 2)
//   STARVE_LIMIT : lost-arbitration cycles before stall_req asserts (>= 1)
//
// Ports:
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous, active-low reset
//   wb_valid     : pipeline writeback request
//   wb_rd        : pipeline destination register
//   wb_data      : pipeline result
//   md_valid     : mul/div result valid
//   md_rd        : mul/div destination register
//   md_data      : mul/div result
//   md_ready     : FIFO can accept (= !full, from occupancy only)
//   reg_write    : register-file write address (registered)
//   write_data   : register-file write data (registered)
//   writeenable  : register-file write strobe (registered)
//   pending_mask : bit r set while a live queued entry targets xr
//   stall_req    : request for a writeback bubble
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic [4:0]  reg_write,
    output logic [31:0] write_data,
    output logic        writeenable,
    output logic [31:0] pending_mask,
    output logic        stall_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // FIFO storage and control state
    // ------------------------------------------------------------------
    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [DEPTH-1:0] live_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    // ------------------------------------------------------------------
    // Arbitration decode
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic head_live;
    logic head_dead;
    logic wb_grant;
    logic md_grant;
    logic push;
    logic pop;

    // A live bit is cleared when its slot is popped, so a set bit always
    // belongs to a stored entry and the head needs no separate valid check.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign head_live = live_q[rd_ptr];
    assign head_dead = !empty && !head_live;

    // A WB write to x0 is architecturally a no-op, so it does not claim
    // the port and the head may go through in the same cycle.
    assign wb_grant  = wb_valid && (wb_rd != 5'd0);
    assign md_grant  = !wb_grant && head_live;

    // Dead heads drain even while WB owns the port.
    assign pop       = md_grant || head_dead;

    // Readiness looks only at occupancy: a full FIFO refuses an entry even
    // in a cycle where it also dequeues.
    assign md_ready  = !full;
    assign push      = md_valid && md_ready;

    assign stall_req = (starve_cnt == STARVE_MAX);

    // ------------------------------------------------------------------
    // Next live bits: kill, then pop, then enqueue.
    // The enqueue slot is free whenever push is set, so it never overlaps
    // the popped slot. Because it is written last, the incoming entry is
    // not affected by a same-cycle kill.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default every always_comb output first so that no path
        // leaves it unassigned and infers a latch.
        live_next = live_q;
        if (wb_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem[i] == wb_rd) begin
                    live_next[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_next[rd_ptr] = 1'b0;
        end
        if (push) begin
            live_next[wr_ptr] = (md_rd != 5'd0);
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination mask, built from stored state only.
    // ------------------------------------------------------------------
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_mask[rd_mem[i]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO payload. Entries are only observed through live_q, which is
    // reset, so the payload arrays need no reset.
    // ------------------------------------------------------------------
    // NOTE: storage arrays are left out of reset on purpose; validity is
    // tracked by the reset live bits and the payload becomes plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= md_rd;
            data_mem[wr_ptr] <= md_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            live_q <= live_next;
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts cycles in which a live head lost the
    // port to WB. It saturates at STARVE_LIMIT and clears whenever the
    // head leaves, either written or popped dead.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (wb_grant && head_live && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. Address and data hold their last granted
    // values while writeenable is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeenable <= 1'b0;
            reg_write   <= '0;
            write_data  <= '0;
        end else if (wb_grant) begin
            writeenable <= 1'b1;
            reg_write   <= wb_rd;
            write_data  <= wb_data;
        end else if (md_grant) begin
            writeenable <= 1'b1;
            reg_write   <= rd_mem[rd_ptr];
            write_data  <= data_mem[rd_ptr];
        end else begin
            writeenable <= 1'b0;
        end
    end

endmodule
